// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared types and helpers for the io_bank_ctrl slice.
// Holds the config FSM state encoding and the config-word field layout.
package io_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    APPLY,
    TURN
  } state_e;

  localparam int NUM_PADS_DEF = 8;
  localparam int CFG_W        = 2 * NUM_PADS_DEF;
  localparam int DIR_LSB      = 0;
  localparam int ZIN_LSB      = NUM_PADS_DEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/io_sync2.sv
// io_sync2: vector-wide two-flop synchroniser with synchronous reset.
// Used on the pad-to-fabric inbound path of io_bank_ctrl.
module io_sync2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: serial-configured direction/zin controller for an iopad bank.
// Optional loopback path is enabled with `define IO_BANK_LOOPBACK_EN.
module io_bank_ctrl
  import io_bank_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
`ifdef IO_BANK_LOOPBACK_EN
  input  logic                lpbk,
`endif
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_busy,
  output logic                cfg_done,
  input  logic [NUM_PADS-1:0] fab_dout,
  output logic [NUM_PADS-1:0] fab_din,
  output logic [NUM_PADS-1:0] pad_zin,
  output logic [NUM_PADS-1:0] pad_dout,
  output logic [NUM_PADS-1:0] pad_dir,
  input  logic [NUM_PADS-1:0] pad_din
);

  localparam int CW_L    = 2 * NUM_PADS;
  localparam int CNT_W   = clog2(CW_L + 1);
  localparam int TC_W    = (clog2(TURN_CYCLES) > 0) ? clog2(TURN_CYCLES) : 1;
  localparam int ZIN_OFF = DIR_LSB + NUM_PADS;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CW_L - 1);
  localparam logic [TC_W-1:0]  TLOAD = TC_W'(TURN_CYCLES - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TC_W-1:0]     tcnt_q;
  logic [CW_L-1:0]     shadow_q;
  logic [CW_L-1:0]     shadow_d;
  logic [NUM_PADS-1:0] dir_q;
  logic [NUM_PADS-1:0] zin_q;
  logic [NUM_PADS-1:0] force_q;
  logic [NUM_PADS-1:0] sh_dir;
  logic [NUM_PADS-1:0] sh_zin;
  logic [NUM_PADS-1:0] changed;
  logic [NUM_PADS-1:0] pad_dout_q;
  logic [NUM_PADS-1:0] sync_in;
  logic [NUM_PADS-1:0] sync_q;
  logic                pend_q;
  logic                done_q;
  logic                lpbk_w;

`ifdef IO_BANK_LOOPBACK_EN
  assign lpbk_w = lpbk;
`else
  assign lpbk_w = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < CW_L; i++) begin
      if (cnt_q == CNT_W'(i)) shadow_d[i] = cfg_bit;
    end
  end

  assign sh_dir  = shadow_q[DIR_LSB +: NUM_PADS];
  assign sh_zin  = shadow_q[ZIN_OFF +: NUM_PADS];
  assign changed = sh_dir ^ dir_q;

  // no-direction-change path reports done one cycle after zin lands
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      shadow_q <= '0;
      dir_q    <= '1;
      zin_q    <= '1;
      force_q  <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= pend_q;
      pend_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (cfg_valid) begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= APPLY;
          end
        end
        APPLY: begin
          if (changed == '0) begin
            zin_q   <= sh_zin;
            pend_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            force_q <= changed;
            tcnt_q  <= TLOAD;
            state_q <= TURN;
          end
        end
        TURN: begin
          if (tcnt_q == '0) begin
            dir_q   <= sh_dir;
            zin_q   <= sh_zin;
            force_q <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pad_dout_q <= '0;
    else     pad_dout_q <= fab_dout;
  end

  assign sync_in = lpbk_w ? pad_dout_q : pad_din;

  io_sync2 #(
    .W(NUM_PADS)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (sync_in),
    .q_o  (sync_q)
  );

  assign fab_din  = sync_q & (dir_q | {NUM_PADS{lpbk_w}});
  assign pad_dout = pad_dout_q;
  assign pad_dir  = dir_q;
  assign pad_zin  = lpbk_w ? '1 : (zin_q | force_q);
  assign cfg_busy = (state_q != IDLE);
  assign cfg_done = done_q;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// tb_io_bank_ctrl: directed self-checking bench for io_bank_ctrl.
// Covers config load/turnaround timing, reset abort and the data paths.
module tb_io_bank_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;
  logic [7:0] fab_dout;
  logic [7:0] fab_din;
  logic [7:0] pad_zin;
  logic [7:0] pad_dout;
  logic [7:0] pad_dir;
  logic [7:0] pad_din;
`ifdef IO_BANK_LOOPBACK_EN
  logic       lpbk;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;

  io_bank_ctrl #(
    .NUM_PADS   (8),
    .TURN_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef IO_BANK_LOOPBACK_EN
    .lpbk     (lpbk),
`endif
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .fab_dout (fab_dout),
    .fab_din  (fab_din),
    .pad_zin  (pad_zin),
    .pad_dout (pad_dout),
    .pad_dir  (pad_dir),
    .pad_din  (pad_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] w, input bit tgl,
                           input int nbits, output int n);
    n = 0;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_bit   = w[i];
      @(posedge clk);
      n++;
      if (tgl && i < nbits - 1) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run_done(input string tag, input int exp_lat,
                          input logic [7:0] tdir, input logic [7:0] tzin);
    int n;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (cfg_done) break;
      chk({tag, "_mid_dir"}, pad_dir, tdir);
      chk({tag, "_mid_zin"}, pad_zin, tzin);
      if (k == 12) n = 13;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    fab_dout  = 8'h00;
    pad_din   = 8'h00;
`ifdef IO_BANK_LOOPBACK_EN
    lpbk      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dir", pad_dir, 8'hFF);
    chk("rst_zin", pad_zin, 8'hFF);
    chk("rst_dout", pad_dout, 8'h00);
    chk("rst_fdin", fab_din, 8'h00);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);

    // dir 0F zin 00: pads 7..4 turn around
    load_word(16'h000F, 1'b0, 16, cyc);
    chk("l1_busy", cfg_busy, 1'b1);
    run_done("l1", 3, 8'hFF, 8'hFF);
    chk("l1_dir", pad_dir, 8'h0F);
    chk("l1_zin", pad_zin, 8'h00);
    @(posedge clk);
    #1;
    chk("l1_done_pulse", cfg_done, 1'b0);
    chk("l1_busy_end", cfg_busy, 1'b0);

    load_word(16'h000F, 1'b0, 16, cyc);
    run_done("l2", 2, 8'h0F, 8'h00);
    chk("l2_dir", pad_dir, 8'h0F);
    chk("l2_zin", pad_zin, 8'h00);

    load_word(16'h000F, 1'b1, 16, cyc);
    chk("l3_cycles", cyc, 31);
    run_done("l3", 2, 8'h0F, 8'h00);
    chk("l3_dir", pad_dir, 8'h0F);

    // every direction flips: all pads held at zin=1 during turnaround
    load_word(16'h0AF0, 1'b0, 16, cyc);
    run_done("l4", 3, 8'h0F, 8'hFF);
    chk("l4_dir", pad_dir, 8'hF0);
    chk("l4_zin", pad_zin, 8'h0A);

    load_word(16'hFFFF, 1'b0, 7, cyc);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_busy", cfg_busy, 1'b0);
    chk("ab_dir", pad_dir, 8'hFF);
    chk("ab_zin", pad_zin, 8'hFF);
    chk("ab_dout", pad_dout, 8'h00);
    chk("ab_done", cfg_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("ab_nodone", cfg_done, 1'b0);
    end

    load_word(16'h000F, 1'b0, 16, cyc);
    run_done("l5", 3, 8'hFF, 8'hFF);
    chk("l5_dir", pad_dir, 8'h0F);
    chk("l5_zin", pad_zin, 8'h00);

    @(negedge clk);
    pad_din  = 8'hA5;
    fab_dout = 8'h3C;
    @(posedge clk);
    #1;
    chk("dp_dout", pad_dout, 8'h3C);
    chk("dp_din1", fab_din, 8'h00);
    @(posedge clk);
    #1;
    chk("dp_din2", fab_din, 8'h05);

`ifdef IO_BANK_LOOPBACK_EN
    @(negedge clk);
    lpbk     = 1'b1;
    fab_dout = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    fab_dout = 8'h3C;
    @(posedge clk);
    #1;
    chk("lb_zin", pad_zin, 8'hFF);
    chk("lb_din1", fab_din, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("lb_din3", fab_din, 8'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bank_ctrl.md
Name: io_bank_ctrl

Overview:
Controller sitting directly upstream of a bank of NUM_PADS iopad instances: drives each pad's zin, dout and direction, and consumes each pad's din. Direction/tristate settings are loaded through a serial configuration chain into a shadow register. They are applied atomically, with a tristate turnaround window. The fabric-side data path is registered: outbound data is one flop; inbound data passes through a 2-flop synchroniser.

Parameters:
NUM_PADS, 8, number of iopads in the bank (1..64)
TURN_CYCLES, 2, cycles all changed pads are held at zin=1 before a new direction takes effect (>=1)

Ports:
clk  input  1  block clock
rst  input  1  synchronous reset, active-high
cfg_start  input  1  pulse; begin a config load (accepted only in IDLE)
cfg_valid  input  1  cfg_bit is valid this cycle (SHIFT only)
cfg_bit  input  1  serial config data, LSB first
cfg_busy  output  1  high in SHIFT, APPLY or TURN
cfg_done  output  1  one-cycle pulse when new config is active
fab_dout  input  NUM_PADS  fabric data to pads
fab_din  output  NUM_PADS  synchronised pad data to fabric
pad_zin  output  NUM_PADS  to iopad zin
pad_dout  output  NUM_PADS  to iopad dout
pad_dir  output  NUM_PADS  to iopad direction (1 = input)
pad_din  input  NUM_PADS  from iopad din

Behaviour:
- Reset, synchronous and active-high: all pads input (pad_dir all 1), pad_zin all 1, pad_dout 0, fab_din 0, sync flops 0, shadow 0, bit counter 0, state IDLE, cfg_busy 0, cfg_done 0.
- Config word: 2*NUM_PADS bits. Bits [NUM_PADS-1:0] are direction; bits [2*NUM_PADS-1:NUM_PADS] are zin. Shifted in LSB first: the first bit accepted lands in bit 0.
- IDLE:
  - cfg_start=1 -> SHIFT; bit counter cleared.
  - cfg_start in any other state is ignored.
- SHIFT:
  - Each cycle with cfg_valid=1 writes cfg_bit into shadow[count] and increments the counter.
  - When the bit at count = 2*NUM_PADS-1 is accepted -> APPLY on the next cycle.
  - cfg_valid=0 stalls with no timeout.
  - Active outputs are unchanged throughout SHIFT.
- APPLY (1 cycle):
  - changed = shadow_dir XOR active_dir.
  - If changed is all-zero: active_zin <= shadow_zin, cfg_done=1 in the following cycle, go to IDLE.
  - Otherwise: pad_zin of changed pads is forced to 1 and TURN is entered with a down-counter loaded to TURN_CYCLES-1.
- TURN:
  - Changed pads keep pad_zin=1 and their old direction; unchanged pads are untouched.
  - When the counter reaches 0: active_dir <= shadow_dir, active_zin <= shadow_zin, cfg_done pulses in the same cycle, go to IDLE.
- Total latency from the last bit accepted to cfg_done:
  - no direction change: 2 cycles;
  - with a direction change: 1 + TURN_CYCLES cycles.
- Data path:
  - pad_dout <= fab_dout every cycle, one-cycle latency; pads in input mode also register this (harmless).
  - fab_din <= sync2 <= sync1 <= pad_din; 2-cycle latency from pad_din to fab_din.
  - For pads with pad_dir=0 (output), the fab_din bit is forced to 0 at the final stage.
- rst asserted in any state returns to IDLE with reset values next cycle. A partial shadow is discarded, and cfg_done is not pulsed.
- Counter width: clog2(2*NUM_PADS+1). No wrap: SHIFT exits exactly at the final bit.

Optional Feature:
IO_BANK_LOOPBACK_EN
- Defined: adds input port lpbk (1 bit). When lpbk=1, fab_din = pad_dout delayed through the same 2-flop path, for all pads regardless of direction, and pad_zin is forced all-1. Config logic is unaffected.
- Undefined: no lpbk port; behaviour exactly as above.

Decomposition:
- Package io_bank_pkg holds:
  - state enum {IDLE, SHIFT, APPLY, TURN} (2-bit);
  - helper function clog2;
  - localparam CFG_W = 2*NUM_PADS default;
  - field-offset constants DIR_LSB=0 and ZIN_LSB=NUM_PADS.
- One natural sub-module: io_sync2, a per-bit-vector 2-flop synchroniser with synchronous reset, instanced once at NUM_PADS width.

Test Plan:
- Reset then idle 5 cycles -> pad_dir=8'hFF, pad_zin=8'hFF, pad_dout=0, fab_din=0, cfg_busy=0.
- Load dir=8'h0F, zin=8'h00 (16 bits, cfg_valid continuous) -> APPLY and TURN with pads 7..4 at zin=1 for 2 cycles; cfg_done 3 cycles after the last bit; then pad_dir=8'h0F, pad_zin=8'h00.
- Reload an identical config -> no TURN; cfg_done exactly 2 cycles after the last bit; outputs unchanged, no zin glitch.
- Config with cfg_valid toggling 1/0 every cycle -> 16 accepted bits take 31 cycles; result identical to the continuous load.
- rst asserted after 7 shifted bits -> IDLE, shadow 0, no cfg_done, outputs at reset values. A fresh full load then succeeds.
- With pads 3..0 input, drive pad_din=8'hA5 -> fab_din=8'h05 two cycles later. fab_dout=8'h3C -> pad_dout=8'h3C one cycle later. With IO_BANK_LOOPBACK_EN and lpbk=1, fab_din=8'h3C three cycles after fab_dout.
